latch_write_sched: RTL and testbench

- Round-robin write scheduler for one shared W-bit bank of D latches (d/e/q/nq cells).
- Up to N requesters each present a write word. The block grants one requester at a time and drives the bank's d and e lines.
- The write sequence is setup, enable, hold, so d is always stable across the entire e-high window and the latches never see d change while transparent.
- Sits between the requesting datapath blocks and the latch bank; it is the only driver of the bank's d and e.

---
 rtl/latch_write_sched.sv | 182 ++++++++++++++++++
 tb/tb_latch_write_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_sched.sv
// rtl/latch_write_sched.sv - round-robin setup/enable/hold write scheduler for a shared D-latch bank
// Define LATCH_WRITE_READBACK_EN to build the HOLD-cycle readback compare and the sticky err output.
module latch_write_sched #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic [W-1:0]   lq,
  output logic [W-1:0]   ld,
  output logic           le,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           busy
`ifdef LATCH_WRITE_READBACK_EN
  ,
  output logic           err
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  if (EN_CYCLES < 1) begin : g_bad_en_cycles
    $error("latch_write_sched: EN_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [W-1:0]    data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            le_q, le_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    words [N];
  logic            found;
  logic [PW-1:0]   win;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      words[j] = wdata[j*W +: W];
    end
  end

  // First asserted requester at or above ptr, wrapping at N.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req[PW'((int'(ptr_q) + i) % N)]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % N);
      end
    end
  end

`ifdef LATCH_WRITE_READBACK_EN
  logic err_q, err_d;
`else
  logic unused_lq;
  assign unused_lq = ^lq;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    le_d    = 1'b0;
    gnt_d   = gnt_q;
    ack_d   = '0;
    busy_d  = 1'b1;
`ifdef LATCH_WRITE_READBACK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        gnt_d  = '0;
        data_d = '0;
        if (found) begin
          sel_d      = win;
          data_d     = words[win];
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ENABLE;
        le_d    = 1'b1;
        cnt_d   = '0;
      end
      ENABLE: begin
        if (cnt_q == CW'(EN_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
          le_d  = 1'b1;
        end
      end
      HOLD: begin
        state_d = DONE;
        ack_d   = gnt_q;
`ifdef LATCH_WRITE_READBACK_EN
        if (lq != data_q) begin
          err_d = 1'b1;
        end
`endif
      end
      DONE: begin
        // d is released only after e has been low for HOLD and DONE.
        state_d = IDLE;
        ptr_d   = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);
        data_d  = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      le_q    <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
`ifdef LATCH_WRITE_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      le_q    <= le_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef LATCH_WRITE_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign ld   = data_q;
  assign le   = le_q;
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;
`ifdef LATCH_WRITE_READBACK_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_latch_write_sched.sv
// tb/tb_latch_write_sched.sv - scoreboard bench for latch_write_sched
module tb_latch_write_sched;
  localparam int N = 4;
  localparam int W = 8;
  parameter int EN = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0]   lq;
  logic [W-1:0]   ld;
  logic           le;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
`ifdef LATCH_WRITE_READBACK_EN
  logic           err;
`endif

  always #5 clk = ~clk;

  latch_write_sched #(.N(N), .W(W), .EN_CYCLES(EN)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .lq    (lq),
    .ld    (ld),
    .le    (le),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy)
`ifdef LATCH_WRITE_READBACK_EN
    , .err (err)
`endif
  );

  // Behavioural latch bank: transparent while e is high.
  logic [W-1:0] bank = '0;
  logic         lq_fault = 1'b0;
  always @(negedge clk) if (le) bank <= ld;
  assign lq = lq_fault ? '0 : bank;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           cyc_at;
  } exp_t;

  exp_t exp_q[$];
  int   ack_idx_log[$];
  int   ack_cyc_log[$];
  int   cyc = 0;
  int   m_ptr = 0;
  int   m_free = 0;
  int   m_win;
  exp_t m_e;

  // Reference model: a grant happens at the first free edge with any request;
  // ack follows 3+EN cycles later and the next grant is possible 4+EN edges later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ptr  = 0;
        m_free = cyc + 1;
        exp_q.delete();
      end else if (cyc >= m_free && req != '0) begin
        m_win = -1;
        for (int i = 0; i < N; i++) begin
          if (m_win < 0 && req[(m_ptr + i) % N]) m_win = (m_ptr + i) % N;
        end
        m_e.idx    = m_win;
        m_e.data   = wdata[m_win*W +: W];
        m_e.cyc_at = cyc + 3 + EN;
        exp_q.push_back(m_e);
        m_ptr  = (m_win + 1) % N;
        m_free = cyc + 4 + EN;
      end
      cyc = cyc + 1;
    end
  end

  exp_t         got;
  int           le_run = 0;
  logic [W-1:0] le_ld = '0;
  bit           le_abort = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (le) begin
        if (le_run == 0) begin
          le_ld    = ld;
          le_abort = 1'b0;
        end else begin
          chk("ld_stable_while_le", ld, le_ld);
        end
        le_run++;
      end else if (le_run > 0) begin
        if (!le_abort) chk("le_width", le_run, EN);
        le_run = 0;
      end
      if (rst) le_abort = 1'b1;

      if (!rst) begin
        if (ack != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: got ack=%b expected none", ack);
          end else begin
            got = exp_q.pop_front();
            chk("ack_onehot", ack, 64'd1 << got.idx);
            chk("gnt_at_ack", gnt, 64'd1 << got.idx);
            chk("ack_cycle", cyc, got.cyc_at);
            chk("ack_data", ld, got.data);
            ack_idx_log.push_back(got.idx);
            ack_cyc_log.push_back(cyc);
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc_at) begin
          checks++;
          errors++;
          $display("FAIL ack_missing: got no ack for requester %0d expected at cycle %0d", exp_q[0].idx, exp_q[0].cyc_at);
          exp_q.delete(0);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Requesters hold req until their ack; waits for the scheduler to drain.
  task automatic settle(input string tag);
    int n;
    n = 0;
    while ((req != '0 || busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    end
    chk({tag, "_settled"}, {req, busy}, 0);
  endtask

  // Cycle c is the clock period after edge c-1; the request is sampled at edge 0.
  task automatic dir_write(input int idx, input logic [W-1:0] val, input bit midop, input string tag);
    @(posedge clk); #1;
    req[idx] = 1'b1;
    wdata[idx*W +: W] = val;
    for (int c = 1; c <= 4 + EN; c++) begin
      @(posedge clk); #1;
      if (midop && c == 1) req[idx] = 1'b0;
      if (midop && c == 2) wdata[idx*W +: W] = {W{1'b1}};
      if (!midop && c == 4 + EN) req[idx] = 1'b0;
      @(negedge clk);
      chk($sformatf("%s_gnt_c%0d", tag, c), gnt, (c <= 3 + EN) ? (64'd1 << idx) : 64'd0);
      chk($sformatf("%s_ld_c%0d", tag, c), ld, (c <= 3 + EN) ? 64'(val) : 64'd0);
      chk($sformatf("%s_le_c%0d", tag, c), le, (c >= 2 && c <= 1 + EN) ? 64'd1 : 64'd0);
      chk($sformatf("%s_ack_c%0d", tag, c), ack, (c == 3 + EN) ? (64'd1 << idx) : 64'd0);
      chk($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 3 + EN) ? 64'd1 : 64'd0);
    end
  endtask

  int cool [N];
  bit reraise [N];
  int base;
  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ld", ld, 0);
    chk("reset_le", le, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    dir_write(2, 8'hA5, 1'b0, "single");
    dir_write(1, 8'h3C, 1'b1, "midop");

    // Reset in the first ENABLE cycle; pointer was 2 before, so 1001 shows it was cleared.
    @(posedge clk); #1;
    req[3] = 1'b1;
    wdata[3*W +: W] = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("le_before_reset", le, 1);
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    chk("midreset_ld", ld, 0);
    chk("midreset_le", le, 0);
    chk("midreset_gnt", gnt, 0);
    chk("midreset_busy", busy, 0);
    @(posedge clk); #1;
    chk("midreset_ack", ack, 0);
    rst = 1'b0;
    req = 4'b1001;
    wdata[0 +: W] = 8'h12;
    wdata[3*W +: W] = 8'h34;
    @(posedge clk); #1;
    chk("post_reset_grant", gnt, 4'b0001);
    settle("post_reset");

`ifdef LATCH_WRITE_READBACK_EN
    chk("err_idle", err, 0);
    lq_fault = 1'b1;
    dir_write(0, 8'h5A, 1'b0, "rb_bad");
    chk("err_set", err, 1);
    lq_fault = 1'b0;
    dir_write(1, 8'h5A, 1'b0, "rb_good");
    chk("err_sticky", err, 1);
    do_reset(2);
    chk("err_cleared", err, 0);
    dir_write(2, 8'h5A, 1'b0, "rb_clean");
    chk("err_clean", err, 0);
`endif

    // All requesters asserting: each drops on its ack and re-raises one cycle later.
    do_reset(2);
    base = ack_idx_log.size();
    for (int i = 0; i < N; i++) begin
      wdata[i*W +: W] = W'($urandom);
      reraise[i] = 1'b0;
    end
    req = '1;
    n = 0;
    while (ack_idx_log.size() < base + 2 * N && n < 2 * N * (4 + EN) + 20) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < N; i++) begin
        if (reraise[i]) begin
          req[i] = 1'b1;
          wdata[i*W +: W] = W'($urandom);
          reraise[i] = 1'b0;
        end
        if (ack[i]) begin
          req[i] = 1'b0;
          reraise[i] = 1'b1;
        end
      end
    end
    chk("rr_ack_count", ack_idx_log.size() >= base + 2 * N, 1);
    for (int k = 0; k < 2 * N && base + k < ack_idx_log.size(); k++) begin
      chk($sformatf("rr_order_%0d", k), ack_idx_log[base + k], k % N);
      if (k > 0) chk($sformatf("rr_spacing_%0d", k), ack_cyc_log[base + k] - ack_cyc_log[base + k - 1], 4 + EN);
    end
    settle("rr");

    // Random traffic: early withdrawals, data changes during operations, varied re-request gaps.
    base = ack_idx_log.size();
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            req[i] = 1'b0;
            cool[i] = $urandom_range(0, 3);
          end else if ($urandom_range(0, 99) == 0) begin
            req[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            wdata[i*W +: W] = W'($urandom);
          end
        end else if (cool[i] > 0) begin
          cool[i]--;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          wdata[i*W +: W] = W'($urandom);
        end
      end
    end
    settle("random");
    chk("random_acks_seen", ack_idx_log.size() > base + 100, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef LATCH_WRITE_READBACK_EN
    chk("err_random", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
